input_repeat_engine: RTL and testbench

//  N-channel key-to-command conditioner between the keyboard decoder and the game FSM.

---
 rtl/input_repeat_engine.sv | 157 +++++++++++++++
 tb/tb_input_repeat_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/input_repeat_engine.sv
// Key-to-command conditioner: turns level key inputs into one-clk command
// pulses with per-channel one-shot, delayed-auto-repeat or fast-repeat modes.
module input_repeat_engine #(
  parameter int                N_CH    = 5,
  parameter int                TIMER_W = 6,
  parameter logic [2*N_CH-1:0] MODE    = 10'h025,
  parameter bit                OPP_EN  = 1'b1,
  parameter int                OPP_A   = 0,
  parameter int                OPP_B   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tick,
  input  logic [TIMER_W-1:0] cfg_delay,
  input  logic [TIMER_W-1:0] cfg_speed,
  input  logic [TIMER_W-1:0] cfg_fast,
  input  logic [N_CH-1:0]    raw,
  output logic [N_CH-1:0]    cmd,
  output logic [N_CH-1:0]    held
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HOLD
  } state_t;

  localparam logic [1:0] M_DAS  = 2'd1;
  localparam logic [1:0] M_FAST = 2'd2;

  state_t             st_q  [N_CH];
  state_t             st_d  [N_CH];
  logic [TIMER_W-1:0] cnt_q [N_CH];
  logic [TIMER_W-1:0] cnt_d [N_CH];

  logic [N_CH-1:0]    press;
  logic [N_CH-1:0]    pulse;
  logic [N_CH-1:0]    sup;
  logic               last_q;
  logic               last_d;
  logic               both;
  logic [TIMER_W-1:0] dly;
  logic [TIMER_W-1:0] spd;
  logic [TIMER_W-1:0] fst;
  logic [TIMER_W-1:0] per;
  logic [TIMER_W:0]   inc;
  logic [TIMER_W-1:0] sat;
  logic [1:0]         m;

  // Zero-length timings behave as one tick.
  assign dly = (cfg_delay == '0) ? TIMER_W'(1) : cfg_delay;
  assign spd = (cfg_speed == '0) ? TIMER_W'(1) : cfg_speed;
  assign fst = (cfg_fast  == '0) ? TIMER_W'(1) : cfg_fast;

  always_comb begin
    press = raw & ~held;
    both  = OPP_EN && raw[OPP_A] && raw[OPP_B];

    // last_d: 0 = channel A is the newest press, 1 = channel B.
    if (press[OPP_A])
      last_d = 1'b0;
    else if (press[OPP_B])
      last_d = 1'b1;
    else
      last_d = last_q;

    sup = '0;
    if (both) begin
      sup[OPP_A] = last_d;
      sup[OPP_B] = ~last_d;
    end

    pulse = '0;
    m     = '0;
    per   = '0;
    inc   = '0;
    sat   = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      m   = MODE[2*i +: 2];
      per = (m == M_FAST) ? fst : spd;
      inc = {1'b0, cnt_q[i]} + (TIMER_W+1)'(1);
      sat = inc[TIMER_W] ? '1 : inc[TIMER_W-1:0];

      if (!raw[i]) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
      end else if (press[i]) begin
        pulse[i] = 1'b1;
        cnt_d[i] = '0;
        unique case (m)
          M_DAS:   st_d[i] = DELAY;
          M_FAST:  st_d[i] = REPEAT;
          default: st_d[i] = HOLD;
        endcase
      end else if (tick) begin
        unique case (st_q[i])
          DELAY: begin
            if (inc >= {1'b0, dly}) begin
              pulse[i] = 1'b1;
              st_d[i]  = REPEAT;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = sat;
            end
          end
          REPEAT: begin
            if (inc >= {1'b0, per}) begin
              pulse[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = sat;
            end
          end
          default: ;
        endcase
      end

      // The older key of an opposing pair is parked until the newer one lets go.
      if (sup[i]) begin
        pulse[i] = 1'b0;
        st_d[i]  = DELAY;
        cnt_d[i] = '0;
      end

      if (!en) begin
        pulse[i] = 1'b0;
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd    <= '0;
      held   <= '0;
      last_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      cmd    <= pulse;
      held   <= raw;
      last_q <= last_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_input_repeat_engine.sv
// Directed bench for input_repeat_engine: cycle table plus
// long-hold, opposing-pair, reset and zero-delay sequences.
module tb_input_repeat_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       tick;
  logic [5:0] cfg_delay;
  logic [5:0] cfg_speed;
  logic [5:0] cfg_fast;
  logic [4:0] raw;
  logic [4:0] cmd;
  logic [4:0] held;

  int n_chk = 0;
  int n_err = 0;
  int tcnt  = 0;
  int log_q [$];

  always #5 clk = ~clk;

  input_repeat_engine dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tick      (tick),
    .cfg_delay (cfg_delay),
    .cfg_speed (cfg_speed),
    .cfg_fast  (cfg_fast),
    .raw       (raw),
    .cmd       (cmd),
    .held      (held)
  );

  typedef struct packed {
    logic [4:0] raw;
    logic       tick;
    logic       en;
    logic [4:0] cmd;
  } vec_t;

  vec_t tbl [30];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] r, input logic tk);
    raw  = r;
    tick = tk;
    @(posedge clk);
    #1;
    if (tk) tcnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(5'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Run n cycles with a tick on every tenth, logging tick counts at ch pulses.
  task automatic run(input logic [4:0] r, input int n, input int ch);
    for (int k = 0; k < n; k++) begin
      step(r, (k % 10) == 9);
      if (cmd[ch]) log_q.push_back(tcnt);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tick = 1'b0; raw = '0;
    cfg_delay = 6'd2; cfg_speed = 6'd1; cfg_fast = 6'd2;

    tbl[0]  = '{5'b00001, 1'b0, 1'b1, 5'b00001};
    tbl[1]  = '{5'b00001, 1'b0, 1'b1, 5'b00000};
    tbl[2]  = '{5'b00001, 1'b1, 1'b1, 5'b00000};
    tbl[3]  = '{5'b00001, 1'b1, 1'b1, 5'b00001};
    tbl[4]  = '{5'b00001, 1'b1, 1'b1, 5'b00001};
    tbl[5]  = '{5'b00001, 1'b0, 1'b1, 5'b00000};
    tbl[6]  = '{5'b00000, 1'b1, 1'b1, 5'b00000};
    tbl[7]  = '{5'b00100, 1'b1, 1'b1, 5'b00100};
    tbl[8]  = '{5'b00100, 1'b1, 1'b1, 5'b00000};
    tbl[9]  = '{5'b00100, 1'b1, 1'b1, 5'b00100};
    tbl[10] = '{5'b01100, 1'b0, 1'b1, 5'b01000};
    tbl[11] = '{5'b01100, 1'b1, 1'b1, 5'b00000};
    tbl[12] = '{5'b01100, 1'b1, 1'b1, 5'b00100};
    tbl[13] = '{5'b00000, 1'b0, 1'b1, 5'b00000};
    tbl[14] = '{5'b10000, 1'b0, 1'b1, 5'b10000};
    tbl[15] = '{5'b00000, 1'b0, 1'b1, 5'b00000};
    tbl[16] = '{5'b00011, 1'b0, 1'b1, 5'b00001};
    tbl[17] = '{5'b00011, 1'b1, 1'b1, 5'b00000};
    tbl[18] = '{5'b00011, 1'b1, 1'b1, 5'b00001};
    tbl[19] = '{5'b00010, 1'b0, 1'b1, 5'b00000};
    tbl[20] = '{5'b00010, 1'b1, 1'b1, 5'b00000};
    tbl[21] = '{5'b00010, 1'b1, 1'b1, 5'b00010};
    tbl[22] = '{5'b00011, 1'b0, 1'b1, 5'b00001};
    tbl[23] = '{5'b00000, 1'b0, 1'b1, 5'b00000};
    tbl[24] = '{5'b00001, 1'b0, 1'b0, 5'b00000};
    tbl[25] = '{5'b00001, 1'b1, 1'b1, 5'b00000};
    tbl[26] = '{5'b00001, 1'b1, 1'b1, 5'b00000};
    tbl[27] = '{5'b00000, 1'b0, 1'b1, 5'b00000};
    tbl[28] = '{5'b00001, 1'b0, 1'b1, 5'b00001};
    tbl[29] = '{5'b00000, 1'b0, 1'b1, 5'b00000};

    do_reset();
    check("reset_cmd", int'(cmd), 0);
    check("reset_held", int'(held), 0);

    for (int i = 0; i < 30; i++) begin
      en = tbl[i].en;
      step(tbl[i].raw, tbl[i].tick);
      check($sformatf("tbl%0d_cmd", i), int'(cmd), int'(tbl[i].cmd));
      check($sformatf("tbl%0d_held", i), int'(held), int'(tbl[i].raw));
    end
    en = 1'b1;

    cfg_delay = 6'd16; cfg_speed = 6'd4; cfg_fast = 6'd2;

    // Long DAS hold on ch0, then release.
    do_reset();
    tcnt = 0; log_q.delete();
    run(5'b00001, 310, 0);
    check("das_count", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      check($sformatf("das_pulse%0d", i), log_q[i], (i == 0) ? 0 : 12 + 4 * i);
    log_q.delete();
    run(5'b00000, 50, 0);
    check("das_release", log_q.size(), 0);

    // ch1 pressed while ch0 held, then ch1 released.
    do_reset();
    tcnt = 0; log_q.delete();
    run(5'b00001, 55, 0);
    check("opp_first", log_q.size(), 1);
    step(5'b00011, 1'b0);
    check("opp_takeover", int'(cmd), 5'b00010);
    log_q.delete();
    run(5'b00011, 100, 0);
    check("opp_suppressed", log_q.size(), 0);
    tcnt = 0; log_q.delete();
    run(5'b00001, 200, 0);
    check("opp_resume_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("opp_resume0", log_q[0], 16);
      check("opp_resume1", log_q[1], 20);
    end

    // Reset in the middle of a FAST repeat with the key still down.
    do_reset();
    step(5'b00100, 1'b0);
    check("fast_press", int'(cmd), 5'b00100);
    for (int k = 0; k < 5; k++) step(5'b00100, 1'b1);
    rst = 1'b1;
    step(5'b00100, 1'b1);
    check("midrst_cmd", int'(cmd), 0);
    check("midrst_held", int'(held), 0);
    rst = 1'b0;
    step(5'b00100, 1'b0);
    check("rst_release_pulse", int'(cmd), 5'b00100);

    // Zero delay repeats on the very first tick.
    cfg_delay = 6'd0;
    do_reset();
    step(5'b00001, 1'b0);
    check("z_press", int'(cmd), 5'b00001);
    step(5'b00001, 1'b0);
    check("z_idle", int'(cmd), 0);
    step(5'b00001, 1'b1);
    check("z_first_tick", int'(cmd), 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
